lsu_mem_stage: RTL and testbench

//  Memory-stage load/store unit of the 5-stage RV32I pipeline, directly upstream of the MEM/WB buffer.
//  - Takes the memory-stage instruction, ALU address and store data.
//  - Runs a request/ready/rvalid handshake with data memory.
//  - Formats load data (byte/half, sign/zero ext) into out_data_M.
//  - Holds the pipeline via stall_M until the access retires.

---
 rtl/lsu_mem_stage.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: data-memory handshake and load formatting.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int          ADDR_W     = 32,
  parameter logic [31:0] RESET_DATA = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_M,
  input  logic [31:0]       alu_out_M,
  input  logic [31:0]       store_data_M,
  input  logic              rd_en_M,
  input  logic              wr_en_M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       out_data_M,
  output logic              stall_M,
  output logic              misalign_M
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DONE
  } state_t;

  state_t      state;
  logic        mis_q;
  logic        mis_c;
  logic        acc;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] ld_c;
  logic [4:0]  bsh;
  logic [7:0]  bval;
  logic [15:0] hval;
  logic        unused;

  assign acc     = rd_en_M | wr_en_M;
  assign f3      = inst_M[14:12];
  assign a       = alu_out_M[1:0];
  assign is_byte = (f3[1:0] == 2'b00);
  assign is_half = (f3[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;

`ifdef MISALIGN_TRAP_EN
  assign mis_c      = (is_half & a[0]) | (is_word & (a != 2'b00));
  assign misalign_M = mis_q & (state == S_DONE);
`else
  assign mis_c      = 1'b0;
  assign misalign_M = 1'b0;
`endif

  assign unused = ^{inst_M[31:15], inst_M[11:0], mis_q};

  always_comb begin
    be_c = 4'b0000;
    wd_c = 32'h0;
    unique case (1'b1)
      is_byte: begin
        be_c = 4'b0001 << a;
        wd_c = {4{store_data_M[7:0]}};
      end
      is_half: begin
        be_c = a[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{store_data_M[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = store_data_M;
      end
    endcase
  end

  assign bsh  = {a, 3'b000};
  assign bval = mem_rdata[bsh +: 8];
  assign hval = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_c = mem_rdata;
    unique case (1'b1)
      is_byte: ld_c = f3[2] ? {24'h0, bval}
                            : {{24{bval[7]}}, bval};
      is_half: ld_c = f3[2] ? {16'h0, hval}
                            : {{16{hval[15]}}, hval};
      default: ld_c = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mis_q      <= 1'b0;
      out_data_M <= RESET_DATA;
    end else begin
      unique case (state)
        S_IDLE: begin
          mis_q <= 1'b0;
          if (acc) begin
            if (mis_c) begin
              state <= S_DONE;
              mis_q <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ready)
            state <= wr_en_M ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            out_data_M <= ld_c;
            state      <= S_DONE;
          end
        end
        default: begin
          mis_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = (state == S_REQ);
  assign mem_we    = mem_req & wr_en_M;
  assign mem_be    = mem_req ? be_c : 4'b0000;
  assign mem_wdata = mem_req ? wd_c : 32'h0;
  assign mem_addr  = {alu_out_M[ADDR_W-1:2], 2'b00};

  // reset gates the IDLE term so a held instruction cannot stall in reset
  assign stall_M = rst & (((state == S_IDLE) & acc)
                 | (state == S_REQ) | (state == S_WAIT));

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: driver pushes expectations,
// negedge monitor pops and compares on memory requests and retirements.
module tb_lsu_mem_stage;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        lanes;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] out;
    logic        mis;
    int          lat;
  } cmp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_M;
  logic [31:0] alu_out_M;
  logic [31:0] store_data_M;
  logic        rd_en_M;
  logic        wr_en_M;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] out_data_M;
  logic        stall_M;
  logic        misalign_M;

  int   total = 0;
  int   bad   = 0;
  int   run   = 0;
  req_t req_q[$];
  cmp_t cmp_q[$];
  req_t r;
  cmp_t c;

  lsu_mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .inst_M       (inst_M),
    .alu_out_M    (alu_out_M),
    .store_data_M (store_data_M),
    .rd_en_M      (rd_en_M),
    .wr_en_M      (wr_en_M),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_data_M   (out_data_M),
    .stall_M      (stall_M),
    .misalign_M   (misalign_M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_inst(input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd);
    inst_M       = {17'h0, f3, 5'h0, (st ? 7'h23 : 7'h03)};
    alu_out_M    = addr;
    store_data_M = sd;
    rd_en_M      = ld;
    wr_en_M      = st;
  endtask

  task automatic drop_inst();
    rd_en_M = 1'b0;
    wr_en_M = 1'b0;
  endtask

  // one access; expectations are literals from the call site
  task automatic do_acc(input logic ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int rdly,
                        input int vdly, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic [31:0] eout,
                        input logic emis, input int elat);
    req_t rq;
    cmp_t cq;
    rq.addr  = {addr[31:2], 2'b00};
    rq.we    = !ld;
    rq.lanes = !ld;
    rq.be    = ebe;
    rq.wd    = ewd;
    cq.out   = eout;
    cq.mis   = emis;
    cq.lat   = elat;
    if (!emis) req_q.push_back(rq);
    cmp_q.push_back(cq);
    set_inst(ld, !ld, f3, addr, sd);
    @(posedge clk) #1;
    if (!emis) begin
      for (int i = 0; i < rdly; i++) begin
        chk("req_held", {63'h0, mem_req}, 64'h1);
        chk("stall_held", {63'h0, stall_M}, 64'h1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk) #1;
      end
      mem_rvalid = 1'b0;
      mem_ready  = 1'b1;
      @(posedge clk) #1;
      mem_ready = 1'b0;
      if (ld) begin
        for (int i = 1; i < vdly; i++) @(posedge clk) #1;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        @(posedge clk) #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
    drop_inst();
    @(posedge clk) #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        run = 0;
      end else begin
        if (mem_req) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", {32'h0, mem_addr}, 64'hFFFF);
          end else begin
            r = req_q[0];
            chk("req_addr", {32'h0, mem_addr}, {32'h0, r.addr});
            chk("req_we", {63'h0, mem_we}, {63'h0, r.we});
            if (r.lanes) begin
              chk("req_be", {60'h0, mem_be}, {60'h0, r.be});
              chk("req_wdata", {32'h0, mem_wdata}, {32'h0, r.wd});
            end
            if (mem_ready) void'(req_q.pop_front());
          end
        end else begin
          chk("idle_lanes", {27'h0, mem_we, mem_be, mem_wdata}, 64'h0);
        end
        if (stall_M) begin
          run++;
        end else if (run > 0) begin
          if (cmp_q.size() == 0) begin
            chk("unexpected_retire", 64'(run), 64'h0);
          end else begin
            c = cmp_q.pop_front();
            chk("out_data", {32'h0, out_data_M}, {32'h0, c.out});
            chk("misalign", {63'h0, misalign_M}, {63'h0, c.mis});
            chk("latency", 64'(run), 64'(c.lat));
          end
          run = 0;
        end else begin
          chk("misalign_idle", {63'h0, misalign_M}, 64'h0);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    set_inst(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #12;
    chk("rst_req", {63'h0, mem_req}, 64'h0);
    chk("rst_stall", {63'h0, stall_M}, 64'h0);
    chk("rst_out", {32'h0, out_data_M}, 64'h0);
    chk("rst_mis", {63'h0, misalign_M}, 64'h0);
    chk("rst_be", {60'h0, mem_be}, 64'h0);
    #5 rst = 1'b1;
    @(posedge clk) #1;

    // SW 0x100, ready with request
    do_acc(0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0,
           4'b1111, 32'hDEADBEEF, 32'h0, 0, 2);
    // LB 0x203, rvalid two cycles after accept
    do_acc(1, 3'b000, 32'h203, 0, 32'h80123456, 0, 2,
           0, 0, 32'hFFFFFF80, 0, 4);
    // LHU 0x202
    do_acc(1, 3'b101, 32'h202, 0, 32'hBEEF1234, 1, 1,
           0, 0, 32'h0000BEEF, 0, 4);
    // SB 0x1
    do_acc(0, 3'b000, 32'h1, 32'h000000A5, 0, 0, 0,
           4'b0010, 32'hA5A5A5A5, 32'h0000BEEF, 0, 2);
    // LH 0x200 negative half
    do_acc(1, 3'b001, 32'h200, 0, 32'h12348001, 0, 1,
           0, 0, 32'hFFFF8001, 0, 3);
    // LBU 0x201
    do_acc(1, 3'b100, 32'h201, 0, 32'h00009A00, 0, 1,
           0, 0, 32'h0000009A, 0, 3);
    // SH 0x2 upper lanes
    do_acc(0, 3'b001, 32'h2, 32'h1234CAFE, 0, 0, 0,
           4'b1100, 32'hCAFECAFE, 32'h0000009A, 0, 2);
    // f3=110 treated as LW
    do_acc(1, 3'b110, 32'h108, 0, 32'h0BADC0DE, 0, 1,
           0, 0, 32'h0BADC0DE, 0, 3);
    // LW 0x104
    do_acc(1, 3'b010, 32'h104, 0, 32'h12345678, 0, 1,
           0, 0, 32'h12345678, 0, 3);
    // SW with ready withheld five cycles
    do_acc(0, 3'b010, 32'h10, 32'h11223344, 0, 5, 0,
           4'b1111, 32'h11223344, 32'h12345678, 0, 7);

    // reset during WAIT abandons the load
    r.addr  = 32'h300;
    r.we    = 1'b0;
    r.lanes = 1'b0;
    r.be    = 4'b0;
    r.wd    = 32'h0;
    req_q.push_back(r);
    set_inst(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(posedge clk) #1;
    mem_ready = 1'b1;
    @(posedge clk) #1;
    mem_ready = 1'b0;
    chk("wait_stall", {63'h0, stall_M}, 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req", {63'h0, mem_req}, 64'h0);
    chk("midrst_stall", {63'h0, stall_M}, 64'h0);
    chk("midrst_out", {32'h0, out_data_M}, 64'h0);
    drop_inst();
    #4 rst = 1'b1;
    @(posedge clk) #1;
    do_acc(1, 3'b010, 32'h304, 0, 32'hA5A50001, 0, 1,
           0, 0, 32'hA5A50001, 0, 3);

    // LW 0x102 misaligned
`ifdef MISALIGN_TRAP_EN
    do_acc(1, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0, 1,
           0, 0, 32'hA5A50001, 1, 1);
`else
    do_acc(1, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0, 1,
           0, 0, 32'hCAFEF00D, 0, 3);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("req_q_empty", 64'(req_q.size()), 64'h0);
    chk("cmp_q_empty", 64'(cmp_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
